ex_wb_skid: RTL and testbench
=============================

EX_WB_SKID -- requirements
Module: ex_wb_skid

Interface
REQ-001 Parameter: none; all datapaths SHALL be fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 ex_valid  in  1  execute stage presents a result this cycle.
REQ-005 ex_ready  out  1  block can accept an execute result this cycle.
REQ-006 ex_src1  in  32  first adder operand.
REQ-007 ex_src2  in  32  second adder operand.
REQ-008 ex_result  in  32  sum from the 32-bit adder, equal to ex_src1+ex_src2 mod 2^32.
REQ-009 ex_dest  in  3  destination register id.
REQ-010 ex_wen  in  1  register-write enable for this result.
REQ-011 flush  in  1  synchronous discard of all held entries.
REQ-012 wb_valid  out  1  writeback entry is valid.
REQ-013 wb_ready  in  1  writeback consumes the entry this cycle.
REQ-014 wb_result, wb_dest, wb_wen  out  32/3/1  held entry fields.
REQ-015 wb_flags  out  4  {OF,SF,ZF,CF} of the held entry.
REQ-016 wb_count  out  16  count of entries retired to writeback.

Function
REQ-017 An input transfer SHALL occur when ex_valid && ex_ready; an output transfer SHALL occur when wb_valid && wb_ready.
REQ-018 Flags SHALL be computed at capture: CF = (ex_result < ex_src1, unsigned); ZF = (ex_result == 0); SF = ex_result[31]; OF = (ex_src1[31]==ex_src2[31]) && (ex_result[31]!=ex_src1[31]).
REQ-019 Storage SHALL be two entries, main and skid; outputs SHALL always drive the main entry fields.
REQ-020 States: EMPTY (no entries), BUSY (main only), FULL (main and skid).
REQ-021 ex_ready SHALL be 1 in EMPTY and BUSY, 0 in FULL, and 0 while rst_n is low.
REQ-022 wb_valid SHALL be 1 in BUSY and FULL, 0 in EMPTY.
REQ-023 EMPTY: input transfer loads main -> BUSY; otherwise stay.
REQ-024 BUSY, input and output transfer together: main reloads with the new entry, stay BUSY.
REQ-025 BUSY, input transfer only: new entry loads skid -> FULL.
REQ-026 BUSY, output transfer only: -> EMPTY.
REQ-027 FULL, output transfer: skid moves to main -> BUSY; no input is accepted in FULL.
REQ-028 Latency SHALL be one cycle: an entry accepted at edge N is on wb_* with wb_valid=1 after edge N.
REQ-029 Entries SHALL retire in acceptance order; none SHALL be dropped or duplicated.
REQ-030 Held wb_* fields SHALL stay stable while wb_valid && !wb_ready.
REQ-031 flush SHALL force EMPTY at the next edge regardless of state.
REQ-032 Any input or output transfer in the flush cycle SHALL be discarded and SHALL NOT count.
REQ-033 wb_count SHALL increment by 1 on each non-flushed output transfer and SHALL wrap from 0xFFFF to 0x0000.
REQ-034 Payload registers SHALL load only on a transfer, so unused entries hold their last value.

Reset
REQ-035 While rst_n is low, state SHALL be EMPTY, and wb_valid, wb_result, wb_dest, wb_wen, wb_flags, wb_count and skid contents SHALL all be 0.
REQ-036 Reset asserted mid-operation SHALL drop all held entries immediately, without waiting for a clock edge.
REQ-037 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-038 Single transfer: src1=0x7FFFFFFF, src2=0x1, result=0x80000000, dest=3, wen=1, wb_ready=1 -> next cycle wb_valid=1, wb_flags={OF=1,SF=1,ZF=0,CF=0}, wb_count=1.
REQ-039 Carry and zero: src1=0xFFFFFFFF, src2=0x1, result=0x0 -> wb_flags={OF=0,SF=0,ZF=1,CF=1}.
REQ-040 Backpressure: wb_ready=0 while entries A then B arrive -> after B, ex_ready=0 and wb shows A stably; raise wb_ready -> A then B retire in order, ex_ready returns to 1, wb_count=2.
REQ-041 Flush in FULL with ex_valid=1 and wb_ready=1 -> next cycle wb_valid=0, ex_ready=1, wb_count unchanged.
REQ-042 Wrap: force 65536 retirements -> wb_count reads 0x0000.
REQ-043 Async reset in FULL: drop rst_n between edges -> wb_valid=0 and wb_count=0 immediately, ex_ready=0 until release.

Source files
------------

// File: rtl/ex_wb_skid.sv
// ex_wb_skid: two-entry skid buffer between execute and writeback with flag generation
module ex_wb_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_src1,
    input  logic [31:0] ex_src2,
    input  logic [31:0] ex_result,
    input  logic [2:0]  ex_dest,
    input  logic        ex_wen,
    input  logic        flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_result,
    output logic [2:0]  wb_dest,
    output logic        wb_wen,
    output logic [3:0]  wb_flags,
    output logic [15:0] wb_count
);
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_main_result, r_skid_result;
    logic [2:0]  r_main_dest, r_skid_dest;
    logic        r_main_wen, r_skid_wen;
    logic [3:0]  r_main_flags, r_skid_flags, w_flags;
    logic [15:0] r_count;
    logic        w_in, w_out, w_ld_main_in, w_ld_main_skid, w_ld_skid;

    assign w_flags   = {(ex_src1[31] == ex_src2[31]) && (ex_result[31] != ex_src1[31]),
                        ex_result[31], ex_result == 32'd0, ex_result < ex_src1};
    assign ex_ready  = rst_n && (r_state != FULL);
    assign wb_valid  = r_state != EMPTY;
    assign w_in      = ex_valid && ex_ready;
    assign w_out     = wb_valid && wb_ready;
    assign wb_result = r_main_result;
    assign wb_dest   = r_main_dest;
    assign wb_wen    = r_main_wen;
    assign wb_flags  = r_main_flags;
    assign wb_count  = r_count;

    // next state and payload steering; a flush discards every transfer this cycle
    always_comb begin
        w_next         = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_in) begin
                    w_next       = BUSY;
                    w_ld_main_in = 1'b1;
                end
                BUSY: if (w_in && w_out) begin
                    w_ld_main_in = 1'b1;
                end else if (w_in) begin
                    w_next    = FULL;
                    w_ld_skid = 1'b1;
                end else if (w_out) begin
                    w_next = EMPTY;
                end
                FULL: if (w_out) begin
                    w_next         = BUSY;
                    w_ld_main_skid = 1'b1;
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    // state register and retirement counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_count <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_out && !flush) r_count <= r_count + 16'd1;
        end
    end

    // main entry: loads from input or promotes the skid entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_result <= 32'd0;
            r_main_dest   <= 3'd0;
            r_main_wen    <= 1'b0;
            r_main_flags  <= 4'd0;
        end else if (w_ld_main_in) begin
            r_main_result <= ex_result;
            r_main_dest   <= ex_dest;
            r_main_wen    <= ex_wen;
            r_main_flags  <= w_flags;
        end else if (w_ld_main_skid) begin
            r_main_result <= r_skid_result;
            r_main_dest   <= r_skid_dest;
            r_main_wen    <= r_skid_wen;
            r_main_flags  <= r_skid_flags;
        end
    end

    // skid entry: catches the input arriving while main is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_result <= 32'd0;
            r_skid_dest   <= 3'd0;
            r_skid_wen    <= 1'b0;
            r_skid_flags  <= 4'd0;
        end else if (w_ld_skid) begin
            r_skid_result <= ex_result;
            r_skid_dest   <= ex_dest;
            r_skid_wen    <= ex_wen;
            r_skid_flags  <= w_flags;
        end
    end
endmodule

// File: tb/tb_ex_wb_skid.sv
// tb_ex_wb_skid: directed self-checking bench for ex_wb_skid
module tb_ex_wb_skid;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_src1 = 32'd0;
    logic [31:0] ex_src2 = 32'd0;
    logic [31:0] ex_result = 32'd0;
    logic [2:0]  ex_dest = 3'd0;
    logic        ex_wen = 1'b0;
    logic        flush = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_result;
    logic [2:0]  wb_dest;
    logic        wb_wen;
    logic [3:0]  wb_flags;
    logic [15:0] wb_count;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_ret;

    ex_wb_skid dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_result(ex_result),
        .ex_dest(ex_dest), .ex_wen(ex_wen), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
        .wb_dest(wb_dest), .wb_wen(wb_wen), .wb_flags(wb_flags), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] d);
        ex_valid  = v;
        ex_src1   = a;
        ex_src2   = b;
        ex_result = a + b;
        ex_dest   = d;
        ex_wen    = 1'b1;
    endtask

    initial begin
        #2;
        check("rst_ready", ex_ready, 0);
        check("rst_valid", wb_valid, 0);
        check("rst_count", wb_count, 0);
        check("rst_result", wb_result, 0);
        check("rst_flags", wb_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", ex_ready, 1);

        drive(1, 32'h7FFFFFFF, 32'h1, 3'd3);
        wb_ready = 1'b1;
        step();
        ex_valid = 1'b0;
        check("single_valid", wb_valid, 1);
        check("single_result", wb_result, 32'h80000000);
        check("single_dest", wb_dest, 3);
        check("single_wen", wb_wen, 1);
        check("single_flags", wb_flags, 4'b1100);
        step();
        check("single_count", wb_count, 1);
        check("single_empty", wb_valid, 0);

        drive(1, 32'hFFFFFFFF, 32'h1, 3'd5);
        step();
        ex_valid = 1'b0;
        check("carry_result", wb_result, 0);
        check("carry_flags", wb_flags, 4'b0011);
        step();
        check("carry_count", wb_count, 2);

        wb_ready = 1'b0;
        drive(1, 32'd1, 32'd2, 3'd1);
        step();
        drive(1, 32'd10, 32'd20, 3'd2);
        check("bp_ready_busy", ex_ready, 1);
        step();
        drive(1, 32'd100, 32'd200, 3'd6);
        check("bp_ready_full", ex_ready, 0);
        check("bp_hold_a", wb_result, 3);
        step();
        check("bp_stable_a", wb_result, 3);
        check("bp_stable_dest", wb_dest, 1);
        ex_valid = 1'b0;
        wb_ready = 1'b1;
        step();
        check("bp_b_result", wb_result, 30);
        check("bp_b_dest", wb_dest, 2);
        check("bp_ready_back", ex_ready, 1);
        step();
        check("bp_drained", wb_valid, 0);
        check("bp_count", wb_count, 4);

        wb_ready = 1'b0;
        drive(1, 32'd5, 32'd6, 3'd1);
        step();
        drive(1, 32'd7, 32'd8, 3'd2);
        step();
        drive(1, 32'd9, 32'd9, 3'd4);
        wb_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        ex_valid = 1'b0;
        check("flush_valid", wb_valid, 0);
        check("flush_ready", ex_ready, 1);
        check("flush_count", wb_count, 4);
        step();
        check("flush_nothing", wb_valid, 0);

        wb_ready = 1'b0;
        drive(1, 32'd1, 32'd1, 3'd1);
        step();
        drive(1, 32'd2, 32'd2, 3'd2);
        step();
        ex_valid = 1'b0;
        check("pre_arst_full", ex_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", wb_valid, 0);
        check("arst_count", wb_count, 0);
        check("arst_ready", ex_ready, 0);
        check("arst_result", wb_result, 0);
        step();
        check("arst_ready_held", ex_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'd40, 32'd2, 3'd7);
        step();
        check("first_xfer", wb_valid, 1);
        check("first_result", wb_result, 42);

        wb_ready = 1'b1;
        n_ret = 0;
        while (n_ret < 65536) begin
            if (n_ret == 65535) check("wrap_ffff", wb_count, 16'hFFFF);
            if (wb_valid) n_ret++;
            step();
        end
        ex_valid = 1'b0;
        wb_ready = 1'b0;
        check("wrap_zero", wb_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
